// File: rtl/la_capture_pkg.sv
// Shared definitions for the logic-analyser capture sequencer: state encoding and default widths.
package la_capture_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_t;

    function automatic logic is_capturing(input cap_state_t s);
        return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/la_capture_cnt.sv
// Loadable down-counter for the pre/post-trigger windows; 'last' marks the final sample.
module la_capture_cnt
    import la_capture_pkg::*;
#(
    parameter int W = ADDR_W_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: circular sample writes, pre-trigger fill, trigger arm/record, post-trigger count.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no capture; waiting for START
//  ST_PRE   | filling the pre-trigger window, trigger evaluation disabled
//  ST_ARMED | writing circularly, waiting for TRIG_IN/FORCE_TRG on a sample
//  ST_POST  | writing the post-trigger samples
//  ST_DONE  | capture complete, memory ready for readback
module la_capture_ctrl
    import la_capture_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [ADDR_W-1:0] PRE_CNT,
    input  logic [ADDR_W-1:0] POST_CNT,
    input  logic              CLK_EN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              TRIG_IN,
    input  logic              FORCE_TRG,
    output logic              TRG_EV_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic [ADDR_W-1:0] TRIG_ADDR,
    output logic              BUSY,
    output logic              DONE,
    output logic [2:0]        STATE
);

    cap_state_t        state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] post_cnt_q;
    logic              wr_en;
    logic              trig_hit;
    logic              start_ok;
    logic              pre_last;
    logic              post_last;

    // ABORT suppresses both the write and any restart in the same cycle
    assign wr_en    = is_capturing(state) && CLK_EN && !ABORT;
    assign trig_hit = (state == ST_ARMED) && wr_en && (TRIG_IN || FORCE_TRG);
    assign start_ok = START && !ABORT && ((state == ST_IDLE) || (state == ST_DONE));

    la_capture_cnt #(.W(ADDR_W)) u_pre_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (start_ok),
        .load_val (PRE_CNT),
        .dec      (wr_en && (state == ST_PRE)),
        .last     (pre_last)
    );

    la_capture_cnt #(.W(ADDR_W)) u_post_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (trig_hit),
        .load_val (post_cnt_q),
        .dec      (wr_en && (state == ST_POST)),
        .last     (post_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (ABORT) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_nx = (PRE_CNT == '0) ? ST_ARMED : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (wr_en && pre_last) begin
                        state_nx = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        state_nx = (post_cnt_q == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (wr_en && post_last) begin
                        state_nx = ST_DONE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Status outputs follow the next state so they line up with STATE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr        <= '0;
            post_cnt_q <= '0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_DATA   <= '0;
            TRIG_ADDR  <= '0;
            TRG_EV_EN  <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            if (start_ok) begin
                ptr        <= '0;
                post_cnt_q <= POST_CNT;
            end else if (wr_en) begin
                ptr <= ptr + ADDR_W'(1);
            end
            MEM_WE <= wr_en;
            if (wr_en) begin
                MEM_ADDR <= ptr;
                MEM_DATA <= DATA_IN;
            end
            if (trig_hit) begin
                TRIG_ADDR <= ptr;
            end
            TRG_EV_EN <= (state_nx == ST_ARMED);
            BUSY      <= is_capturing(state_nx);
            DONE      <= (state_nx == ST_DONE);
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Randomized bench for la_capture_ctrl against a sample-index reference model.
module tb_la_capture_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START, ABORT, CLK_EN, TRIG_IN, FORCE_TRG;
    logic [AW-1:0] PRE_CNT, POST_CNT;
    logic [DW-1:0] DATA_IN;
    logic          TRG_EV_EN, MEM_WE, BUSY, DONE;
    logic [AW-1:0] MEM_ADDR, TRIG_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic [2:0]    STATE;

    la_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .ABORT     (ABORT),
        .PRE_CNT   (PRE_CNT),
        .POST_CNT  (POST_CNT),
        .CLK_EN    (CLK_EN),
        .DATA_IN   (DATA_IN),
        .TRIG_IN   (TRIG_IN),
        .FORCE_TRG (FORCE_TRG),
        .TRG_EV_EN (TRG_EV_EN),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DATA  (MEM_DATA),
        .TRIG_ADDR (TRIG_ADDR),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .STATE     (STATE)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: capture described by sample index n and trigger sample index
    bit m_active, m_done, m_trig_seen;
    int m_n, m_trig_n, m_pre, m_post;
    bit e_we;
    int e_addr, e_data, e_trig_addr;

    function automatic int m_phase();
        if (m_done)            return 4;
        if (!m_active)         return 0;
        if (m_n < m_pre)       return 1;
        if (!m_trig_seen)      return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_trig_seen = 0;
        m_n = 0; m_trig_n = 0; m_pre = 0; m_post = 0;
        e_we = 0; e_addr = 0; e_data = 0; e_trig_addr = 0;
    endtask

    task automatic model_edge();
        int ph;
        ph   = m_phase();
        e_we = 0;
        if (ABORT) begin
            m_active = 0;
            m_done   = 0;
        end else if (ph >= 1 && ph <= 3) begin
            if (CLK_EN) begin
                e_we   = 1;
                e_addr = m_n % DEPTH;
                e_data = int'(DATA_IN);
                if (ph == 2 && (TRIG_IN || FORCE_TRG)) begin
                    m_trig_seen = 1;
                    m_trig_n    = m_n;
                    e_trig_addr = m_n % DEPTH;
                end
                m_n++;
                if (m_trig_seen && m_n > m_trig_n + m_post) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else if (START) begin
            m_active = 1; m_done = 0; m_trig_seen = 0; m_n = 0;
            m_pre  = int'(PRE_CNT);
            m_post = int'(POST_CNT);
        end
    endtask

    task automatic check_outputs();
        int ph;
        ph = m_phase();
        check_val("state", 32'(STATE), ph);
        check_val("busy", 32'(BUSY), (ph >= 1 && ph <= 3) ? 1 : 0);
        check_val("done", 32'(DONE), (ph == 4) ? 1 : 0);
        check_val("trg_ev_en", 32'(TRG_EV_EN), (ph == 2) ? 1 : 0);
        check_val("mem_we", 32'(MEM_WE), e_we);
        if (e_we) begin
            check_val("mem_addr", 32'(MEM_ADDR), e_addr);
            check_val("mem_data", 32'(MEM_DATA), e_data);
        end
        check_val("trig_addr", 32'(TRIG_ADDR), e_trig_addr);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        START = 0; ABORT = 0; CLK_EN = 0; TRIG_IN = 0; FORCE_TRG = 0;
        DATA_IN = DW'($urandom);
    endtask

    // en_div 0 = random strobe; trig_at = sample count after which the trigger rises
    task automatic capture(input int pre, input int post, input int en_div, input int trig_at,
                           input bit use_force, input int abort_at, input int budget,
                           output int last_addr);
        int cyc;
        bit trig_cond;
        START    = 1;
        PRE_CNT  = AW'(pre);
        POST_CNT = AW'(post);
        CLK_EN   = 1'($urandom_range(0, 1));
        DATA_IN  = DW'($urandom);
        step();
        START     = 0;
        last_addr = -1;
        cyc       = 0;
        while ((m_phase() inside {1, 2, 3}) && cyc < budget) begin
            CLK_EN    = (en_div == 0) ? 1'($urandom_range(0, 1)) : ((cyc % en_div) == 0);
            DATA_IN   = DW'($urandom);
            trig_cond = (trig_at >= 0) && (m_n >= trig_at);
            TRIG_IN   = trig_cond && !use_force;
            FORCE_TRG = trig_cond && use_force;
            ABORT     = (cyc == abort_at);
            START     = ABORT ? 1'b1 : ($urandom_range(0, 15) == 0);
            PRE_CNT   = AW'($urandom);
            POST_CNT  = AW'($urandom);
            step();
            if (MEM_WE) last_addr = int'(MEM_ADDR);
            cyc++;
        end
        idle_inputs();
        check_val("cap_end_busy", 32'(BUSY), 0);
        step();
    endtask

    initial begin
        int la;
        RST = 1;
        PRE_CNT = '0; POST_CNT = '0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_state", 32'(STATE), 0);
        check_val("rst_busy", 32'(BUSY), 0);
        check_val("rst_done", 32'(DONE), 0);
        check_val("rst_mem_we", 32'(MEM_WE), 0);
        check_val("rst_trig_addr", 32'(TRIG_ADDR), 0);
        RST = 0;
        repeat (2) step();

        // pre 4, post 3, strobe every 2nd cycle, trigger after 10 samples
        capture(4, 3, 2, 10, 0, -1, 200, la);
        check_val("t1_trig_addr", 32'(TRIG_ADDR), 10);
        check_val("t1_last_addr", la, 13);
        check_val("t1_done", 32'(DONE), 1);

        // zero-length windows, trigger already high
        capture(0, 0, 1, 0, 0, -1, 50, la);
        check_val("t2_trig_addr", 32'(TRIG_ADDR), 0);
        check_val("t2_last_addr", la, 0);
        check_val("t2_done", 32'(DONE), 1);

        // pointer wrap across the top of memory
        capture(DEPTH - 2, 5, 1, DEPTH + 4, 0, -1, DEPTH + 100, la);
        check_val("t3_trig_addr", 32'(TRIG_ADDR), 4);
        check_val("t3_last_addr", la, 9);

        // trigger high throughout PRE is ignored
        capture(8, 2, 1, 0, 0, -1, 100, la);
        check_val("t4_trig_addr", 32'(TRIG_ADDR), 8);
        check_val("t4_last_addr", la, 10);

        // ABORT with START during POST
        capture(3, 40, 1, 5, 0, 10, 200, la);
        check_val("t5_state", 32'(STATE), 0);
        check_val("t5_done", 32'(DONE), 0);
        check_val("t5_mem_we", 32'(MEM_WE), 0);
        check_val("t5_trig_addr", 32'(TRIG_ADDR), 5);

        // async reset while ARMED, then forced trigger
        START = 1; PRE_CNT = AW'(2); POST_CNT = AW'(5);
        step();
        START = 0;
        for (int i = 0; i < 8; i++) begin
            CLK_EN  = 1'($urandom_range(0, 1));
            DATA_IN = DW'($urandom);
            step();
        end
        CLK_EN = 1;
        for (int i = 0; i < 20 && m_phase() != 2; i++) step();
        check_val("t6_armed", 32'(STATE), 2);
        @(posedge CLK);
        #3;
        RST = 1;
        #1;
        check_val("t6_rst_state", 32'(STATE), 0);
        check_val("t6_rst_trg_ev_en", 32'(TRG_EV_EN), 0);
        check_val("t6_rst_busy", 32'(BUSY), 0);
        check_val("t6_rst_mem_addr", 32'(MEM_ADDR), 0);
        model_reset();
        idle_inputs();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 0;
        capture(1, 3, 0, 1, 1, -1, 200, la);
        check_val("t6_trig_addr", 32'(TRIG_ADDR), 1);

        // randomized captures, with occasional abort
        for (int k = 0; k < 40; k++) begin
            capture($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 3),
                    $urandom_range(0, 30), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, 30) : -1, 400, la);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
